amber_csr_arb: RTL and testbench
================================

AMBER_CSR_ARB -- requirements
Module: amber_csr_arb

Interface
REQ-001 Parameter STARVE_LIM, default 8: debug wait cycles before debug gains priority (range 1..15).
REQ-002 iw_clk  in  1  single clock; all state changes on rising edge.
REQ-003 iw_rst_n  in  1  reset, synchronous, active-low.
REQ-004 iw_p_req / iw_p_we  in  1/1  pipeline request, write-enable (CSRRD=0, CSRWR=1).
REQ-005 iw_p_addr / iw_p_wdata  in  12/24  pipeline CSR address, write data.
REQ-006 ow_p_gnt / ow_p_rvalid / ow_p_rdata  out  1/1/24  pipeline accept pulse, completion pulse, response data.
REQ-007 iw_d_req, iw_d_we, iw_d_addr, iw_d_wdata, ow_d_gnt, ow_d_rvalid, ow_d_rdata: debug port, same widths and meaning as REQ-004..006.
REQ-008 ow_csr_we / ow_csr_addr / ow_csr_wdata  out  1/12/24  CSR file write strobe, address, data.
REQ-009 iw_csr_rdata  in  24  CSR file combinational read data for ow_csr_addr.
REQ-010 ow_busy  out  1  high whenever state is not IDLE.

Function
REQ-011 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on any grant, ACCESS->RESP always, RESP->IDLE always.
REQ-012 Grant only in IDLE; ow_x_gnt is combinational, high one cycle; request fields captured at that edge.
REQ-013 Arbitration: pipeline wins when both request, except REQ-022 override.
REQ-014 ACCESS: ow_csr_addr/wdata driven from captured fields; ow_csr_we = captured we AND iw_rst_n; iw_csr_rdata registered at end of ACCESS.
REQ-015 RESP: winner's ow_x_rvalid high exactly one cycle; ow_x_rdata = registered value (for writes: pre-write CSR value).
REQ-016 Latency: gnt cycle N, CSR write/read cycle N+1, rvalid cycle N+2; next grant earliest N+3.
REQ-017 Requester holds req and fields until gnt; dropping req before gnt abandons request, no transaction.
REQ-018 Requests arriving in ACCESS/RESP wait; no grant, no loss.
REQ-019 ow_csr_we low and ow_csr_addr/wdata zero outside ACCESS; ow_x_rdata holds last value until next RESP for that port.
REQ-020 Non-winning port's rvalid and gnt stay low throughout a transaction.

Reset
REQ-021 iw_rst_n low at an edge: state IDLE, all gnt/rvalid/we/busy 0, rdata/addr/wdata 0, starve counter 0; in-flight transaction dropped with no rvalid, and no CSR write in the reset cycle.

Configuration
REQ-022 With AMBER_CSR_ARB_STARVE_EN defined: 4-bit counter increments each cycle iw_d_req is high and not granted (saturating at 15), clears on debug grant; when counter >= STARVE_LIM debug wins over pipeline.
REQ-023 Without AMBER_CSR_ARB_STARVE_EN: no counter logic; strict pipeline priority.

Structure
REQ-024 Shared package amber_csr_pkg holds CSR_AW=12, CSR_DW=24, FSM state encoding, CSR_STATUS address 12'h000.
REQ-025 One sub-module amber_csr_starve (counter and override compare), instantiated only under AMBER_CSR_ARB_STARVE_EN.

Verification
REQ-026 Pipeline write addr 0x321 data 0x00ACE with CSR old value 0 -> gnt N, csr_we N+1 addr 0x321, p_rvalid N+2 rdata 0x000000.
REQ-027 Pipeline read 0x321 after REQ-026 -> p_rvalid at N+2, p_rdata 0x00ACE, csr_we never high.
REQ-028 Both request same cycle, debug read 0x000 -> pipeline granted first, debug granted 3 cycles later, d_rdata = STATUS 0x000001.
REQ-029 Pipeline requests continuously, debug holds req (macro on, STARVE_LIM 8) -> debug granted at first IDLE with counter >= 8; macro off -> never granted.
REQ-030 Reset asserted during ACCESS of a write to 0x321 -> no csr_we, no rvalid, IDLE next cycle, CSR value unchanged.

Source files
------------

// File: rtl/amber_csr_pkg.sv
// Shared definitions for the amber CSR arbiter: bus widths, FSM state
// encoding, well-known CSR addresses and small arithmetic helpers.
package amber_csr_pkg;

    localparam int CSR_AW = 12;
    localparam int CSR_DW = 24;

    // Status register of the CSR file; reads back as 24'h000001 after reset.
    localparam logic [CSR_AW-1:0] CSR_STATUS = 12'h000;

    // Width and ceiling of the debug wait counter.
    localparam int          STARVE_CW  = 4;
    localparam logic [3:0]  STARVE_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_e;

    // Saturating increment used by the debug wait counter.
    function automatic logic [STARVE_CW-1:0] sat_inc(input logic [STARVE_CW-1:0] v);
        if (v == STARVE_MAX) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/amber_csr_starve.sv
// Debug starvation tracker: counts cycles the debug port waits ungranted and
// raises an override once the wait reaches STARVE_LIM. Only instantiated by
// amber_csr_arb when AMBER_CSR_ARB_STARVE_EN is defined.
module amber_csr_starve
    import amber_csr_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic iw_clk,
    input  logic iw_rst_n,
    input  logic iw_d_req,
    input  logic iw_d_gnt,
    output logic ow_override
);

    localparam logic [STARVE_CW-1:0] LIM_C = STARVE_CW'(STARVE_LIM);

    logic [STARVE_CW-1:0] r_cnt;

    // Wait counter: cleared on reset or debug grant, saturating count while debug waits.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_cnt <= 4'd0;
        end else if (iw_d_gnt) begin
            r_cnt <= 4'd0;
        end else if (iw_d_req) begin
            r_cnt <= sat_inc(r_cnt);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign ow_override = (r_cnt >= LIM_C);

endmodule

// File: rtl/amber_csr_arb.sv
// Two-port CSR arbiter (pipeline + debug) in front of a combinational-read CSR
// file. Each transaction is grant (IDLE) -> access (ACCESS) -> response (RESP).
// Optional feature macro: AMBER_CSR_ARB_STARVE_EN enables the debug
// starvation override; without it the pipeline has strict priority.
module amber_csr_arb
    import amber_csr_pkg::*;
#(
    parameter int STARVE_LIM = 8
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_p_req,
    input  logic              iw_p_we,
    input  logic [CSR_AW-1:0] iw_p_addr,
    input  logic [CSR_DW-1:0] iw_p_wdata,
    output logic              ow_p_gnt,
    output logic              ow_p_rvalid,
    output logic [CSR_DW-1:0] ow_p_rdata,
    input  logic              iw_d_req,
    input  logic              iw_d_we,
    input  logic [CSR_AW-1:0] iw_d_addr,
    input  logic [CSR_DW-1:0] iw_d_wdata,
    output logic              ow_d_gnt,
    output logic              ow_d_rvalid,
    output logic [CSR_DW-1:0] ow_d_rdata,
    output logic              ow_csr_we,
    output logic [CSR_AW-1:0] ow_csr_addr,
    output logic [CSR_DW-1:0] ow_csr_wdata,
    input  logic [CSR_DW-1:0] iw_csr_rdata,
    output logic              ow_busy
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_sel_d;      // captured winner: 1 = debug, 0 = pipeline
    logic              r_we;
    logic [CSR_AW-1:0] r_addr;
    logic [CSR_DW-1:0] r_wdata;
    logic              r_p_rvalid;
    logic              r_d_rvalid;
    logic [CSR_DW-1:0] r_p_rdata;
    logic [CSR_DW-1:0] r_d_rdata;
    logic              w_idle;
    logic              w_d_override;
    logic              w_p_gnt;
    logic              w_d_gnt;

`ifdef AMBER_CSR_ARB_STARVE_EN
    amber_csr_starve #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .iw_clk      (iw_clk),
        .iw_rst_n    (iw_rst_n),
        .iw_d_req    (iw_d_req),
        .iw_d_gnt    (w_d_gnt),
        .ow_override (w_d_override)
    );
`else
    assign w_d_override = 1'b0;
`endif

    // No grant is issued while reset is asserted.
    assign w_idle = (r_state == ST_IDLE) && iw_rst_n;

    // Arbitration: pipeline first unless debug has waited long enough.
    always_comb begin
        w_p_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (w_idle) begin
            if (iw_d_req && (w_d_override || !iw_p_req)) begin
                w_d_gnt = 1'b1;
            end else if (iw_p_req) begin
                w_p_gnt = 1'b1;
            end else begin
                w_p_gnt = 1'b0;
            end
        end else begin
            w_d_gnt = 1'b0;
        end
    end

    // Next-state logic for the grant/access/response sequence.
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (w_p_gnt || w_d_gnt) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request's fields at the grant edge.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_sel_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 12'h000;
            r_wdata <= 24'h000000;
        end else if (w_p_gnt) begin
            r_sel_d <= 1'b0;
            r_we    <= iw_p_we;
            r_addr  <= iw_p_addr;
            r_wdata <= iw_p_wdata;
        end else if (w_d_gnt) begin
            r_sel_d <= 1'b1;
            r_we    <= iw_d_we;
            r_addr  <= iw_d_addr;
            r_wdata <= iw_d_wdata;
        end else begin
            r_sel_d <= r_sel_d;
            r_we    <= r_we;
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Latch CSR read data at the end of ACCESS into the winner's response register.
    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            r_p_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_p_rdata  <= 24'h000000;
            r_d_rdata  <= 24'h000000;
        end else begin
            r_p_rvalid <= (r_state == ST_ACCESS) && !r_sel_d;
            r_d_rvalid <= (r_state == ST_ACCESS) && r_sel_d;
            if ((r_state == ST_ACCESS) && !r_sel_d) begin
                r_p_rdata <= iw_csr_rdata;
            end else begin
                r_p_rdata <= r_p_rdata;
            end
            if ((r_state == ST_ACCESS) && r_sel_d) begin
                r_d_rdata <= iw_csr_rdata;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

    // CSR file drive: only during ACCESS, and never write while reset is low.
    always_comb begin
        ow_csr_we    = 1'b0;
        ow_csr_addr  = 12'h000;
        ow_csr_wdata = 24'h000000;
        if (r_state == ST_ACCESS) begin
            ow_csr_we    = r_we && iw_rst_n;
            ow_csr_addr  = r_addr;
            ow_csr_wdata = r_wdata;
        end else begin
            ow_csr_we    = 1'b0;
        end
    end

    assign ow_p_gnt    = w_p_gnt;
    assign ow_d_gnt    = w_d_gnt;
    assign ow_p_rvalid = r_p_rvalid;
    assign ow_d_rvalid = r_d_rvalid;
    assign ow_p_rdata  = r_p_rdata;
    assign ow_d_rdata  = r_d_rdata;
    assign ow_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_amber_csr_arb.sv
// Self-checking bench for amber_csr_arb: a transaction-level model checked
// against the DUT on every cycle, plus directed scenarios with literal values.
module tb_amber_csr_arb;

    localparam int LIM = 8;
`ifdef AMBER_CSR_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we, p_gnt, p_rvalid;
    logic [11:0] p_addr;
    logic [23:0] p_wdata, p_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [11:0] d_addr;
    logic [23:0] d_wdata, d_rdata;
    logic        csr_we, busy;
    logic [11:0] csr_addr;
    logic [23:0] csr_wdata, csr_rdata;

    amber_csr_arb #(.STARVE_LIM(LIM)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n),
        .iw_p_req(p_req), .iw_p_we(p_we), .iw_p_addr(p_addr), .iw_p_wdata(p_wdata),
        .ow_p_gnt(p_gnt), .ow_p_rvalid(p_rvalid), .ow_p_rdata(p_rdata),
        .iw_d_req(d_req), .iw_d_we(d_we), .iw_d_addr(d_addr), .iw_d_wdata(d_wdata),
        .ow_d_gnt(d_gnt), .ow_d_rvalid(d_rvalid), .ow_d_rdata(d_rdata),
        .ow_csr_we(csr_we), .ow_csr_addr(csr_addr), .ow_csr_wdata(csr_wdata),
        .iw_csr_rdata(csr_rdata), .ow_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file environment: STATUS reads 1, everything else 0 until written.
    logic [23:0] mem [0:4095];
    bit          mem_ready;
    assign csr_rdata = mem[csr_addr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 24'h0;
            mem[0]    <= 24'h000001;
            mem_ready <= 1'b1;
        end else if (csr_we) begin
            mem[csr_addr] <= csr_wdata;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model state.
    int          m_age = 0;          // cycles since grant of the in-flight transaction, 0 = none
    bit          m_port = 1'b0;      // 1 = debug owns the transaction
    bit          m_we = 1'b0;
    logic [11:0] m_addr = 12'h0;
    logic [23:0] m_wdata = 24'h0;
    logic [23:0] m_p_rdata = 24'h0;
    logic [23:0] m_d_rdata = 24'h0;
    int          m_wait = 0;
    logic [23:0] m_mem [0:4095];
    bit          m_wr  [0:4095];

    // Observed event bookkeeping used by the directed checks.
    int          we_count = 0, last_we_cyc = -1, p_rv_count = 0, d_rv_count = 0;
    logic [11:0] last_we_addr = 12'h0;

    function automatic logic [23:0] m_read(input logic [11:0] a);
        if (m_wr[a]) return m_mem[a];
        else if (a == 12'h000) return 24'h000001;
        else return 24'h000000;
    endfunction

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin : cmp
        logic        e_pg, e_dg, ovr, e_we;
        logic [11:0] e_addr;
        logic [23:0] e_wd, v;
        ovr  = STARVE_ON && (m_wait >= LIM);
        e_pg = 1'b0;
        e_dg = 1'b0;
        if (rst_n && (m_age == 0)) begin
            if (d_req && (ovr || !p_req)) e_dg = 1'b1;
            else if (p_req) e_pg = 1'b1;
        end
        e_we   = (m_age == 1) && m_we && rst_n;
        e_addr = (m_age == 1) ? m_addr : 12'h0;
        e_wd   = (m_age == 1) ? m_wdata : 24'h0;
        chk("p_gnt", 32'(p_gnt), 32'(e_pg));
        chk("d_gnt", 32'(d_gnt), 32'(e_dg));
        chk("busy", 32'(busy), 32'(m_age != 0));
        chk("csr_we", 32'(csr_we), 32'(e_we));
        chk("csr_addr", 32'(csr_addr), 32'(e_addr));
        chk("csr_wdata", 32'(csr_wdata), 32'(e_wd));
        chk("p_rvalid", 32'(p_rvalid), 32'((m_age == 2) && !m_port));
        chk("d_rvalid", 32'(d_rvalid), 32'((m_age == 2) && m_port));
        chk("p_rdata", 32'(p_rdata), 32'(m_p_rdata));
        chk("d_rdata", 32'(d_rdata), 32'(m_d_rdata));
        if (csr_we) begin
            we_count     <= we_count + 1;
            last_we_cyc  <= cyc;
            last_we_addr <= csr_addr;
        end
        if (p_rvalid) p_rv_count <= p_rv_count + 1;
        if (d_rvalid) d_rv_count <= d_rv_count + 1;
        if (!rst_n) begin
            m_age     <= 0;
            m_p_rdata <= 24'h0;
            m_d_rdata <= 24'h0;
            m_wait    <= 0;
        end else begin
            if (e_dg) m_wait <= 0;
            else if (d_req) m_wait <= (m_wait < 15) ? m_wait + 1 : 15;
            if (m_age == 1) begin
                v = m_read(m_addr);
                if (m_port) m_d_rdata <= v;
                else m_p_rdata <= v;
                if (m_we) begin
                    m_mem[m_addr] <= m_wdata;
                    m_wr[m_addr]  <= 1'b1;
                end
                m_age <= 2;
            end else if (m_age == 2) begin
                m_age <= 0;
            end else if (e_pg || e_dg) begin
                m_port  <= e_dg;
                m_we    <= e_dg ? d_we : p_we;
                m_addr  <= e_dg ? d_addr : p_addr;
                m_wdata <= e_dg ? d_wdata : p_wdata;
                m_age   <= 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on a port: hold until granted, then wait for its response.
    task automatic txn(input bit port, input bit we, input logic [11:0] a, input logic [23:0] wd,
                       output int gcyc, output int vcyc, output logic [23:0] rd);
        gcyc = -1;
        vcyc = -1;
        rd   = 24'h0;
        if (port) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
        else      begin p_req = 1'b1; p_we = we; p_addr = a; p_wdata = wd; end
        for (int i = 0; i < 60 && gcyc < 0; i++) begin
            @(negedge clk);
            if (port ? d_gnt : p_gnt) gcyc = cyc;
        end
        tick();
        if (port) d_req = 1'b0;
        else p_req = 1'b0;
        chk(port ? "d_gnt_timeout" : "p_gnt_timeout", 32'(gcyc >= 0), 32'd1);
        for (int i = 0; i < 10 && vcyc < 0; i++) begin
            @(negedge clk);
            if (port ? d_rvalid : p_rvalid) begin
                vcyc = cyc;
                rd   = port ? d_rdata : p_rdata;
            end
        end
        chk(port ? "d_rvalid_timeout" : "p_rvalid_timeout", 32'(vcyc >= 0), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          g, v, g2, v2, wc, rc, s0, dg;
        logic [23:0] rd, rd2;
        rst_n = 1'b0;
        p_req = 1'b0; p_we = 1'b0; p_addr = 12'h0; p_wdata = 24'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 12'h0; d_wdata = 24'h0;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_p_rdata", 32'(p_rdata), 32'd0);
        chk("reset_csr_we", 32'(csr_we), 32'd0);
        rst_n = 1'b1;
        tick();

        // Pipeline write 0x321 <= 0x00ACE (old value 0).
        txn(1'b0, 1'b1, 12'h321, 24'h00ACE, g, v, rd);
        tick();
        chk("wr_rvalid_latency", 32'(v - g), 32'd2);
        chk("wr_csr_we_cycle", 32'(last_we_cyc - g), 32'd1);
        chk("wr_csr_addr", 32'(last_we_addr), 32'h321);
        chk("wr_old_value", 32'(rd), 32'h000000);
        chk("wr_mem", 32'(mem[12'h321]), 32'h00ACE);

        // Pipeline read back 0x321: no write strobe.
        wc = we_count;
        txn(1'b0, 1'b0, 12'h321, 24'h0, g, v, rd);
        tick();
        chk("rd_rvalid_latency", 32'(v - g), 32'd2);
        chk("rd_data", 32'(rd), 32'h00ACE);
        chk("rd_no_we", 32'(we_count), 32'(wc));

        // Debug pulses a request while busy and drops it: abandoned.
        rc = d_rv_count;
        fork
            txn(1'b0, 1'b1, 12'h055, 24'h123456, g, v, rd);
            begin
                repeat (2) tick();
                d_req = 1'b1; d_we = 1'b1; d_addr = 12'h055; d_wdata = 24'h000BAD;
                tick();
                d_req = 1'b0;
            end
        join
        repeat (4) tick();
        chk("abandon_no_d_rvalid", 32'(d_rv_count), 32'(rc));
        chk("abandon_mem", 32'(mem[12'h055]), 32'h123456);

        // Simultaneous requests: pipeline first, debug STATUS read 3 cycles later.
        fork
            txn(1'b0, 1'b0, 12'h321, 24'h0, g, v, rd);
            txn(1'b1, 1'b0, 12'h000, 24'h0, g2, v2, rd2);
        join
        tick();
        chk("both_d_after_p", 32'(g2 - g), 32'd3);
        chk("both_p_data", 32'(rd), 32'h00ACE);
        chk("both_d_status", 32'(rd2), 32'h000001);
        tick();

        // Continuous pipeline traffic with debug waiting.
        s0 = cyc;
        dg = -1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 12'h000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h000;
        for (int i = 0; i < 40 && dg < 0; i++) begin
            @(negedge clk);
            if (d_gnt) dg = cyc;
        end
        tick();
        if (STARVE_ON) begin
            chk("starve_d_gnt_cycle", 32'(dg - s0), 32'd9);
            p_req = 1'b0;
            d_req = 1'b0;
        end else begin
            chk("strict_no_d_gnt", 32'(dg), 32'hFFFF_FFFF);
            p_req = 1'b0;
            dg = -1;
            for (int i = 0; i < 20 && dg < 0; i++) begin
                @(negedge clk);
                if (d_gnt) dg = cyc;
            end
            tick();
            d_req = 1'b0;
            chk("strict_d_gnt_after_drop", 32'(dg >= 0), 32'd1);
        end
        repeat (4) tick();

        // Reset during ACCESS of a write to 0x321: transaction dropped.
        wc = we_count;
        rc = p_rv_count;
        p_req = 1'b1; p_we = 1'b1; p_addr = 12'h321; p_wdata = 24'h0BEEF;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk);
            if (p_gnt) g = cyc;
        end
        chk("rst_gnt_timeout", 32'(g >= 0), 32'd1);
        tick();
        p_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_access_no_we", 32'(csr_we), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle_next", 32'(busy), 32'd0);
        repeat (4) tick();
        chk("rst_no_rvalid", 32'(p_rv_count), 32'(rc));
        chk("rst_no_write", 32'(we_count), 32'(wc));
        chk("rst_mem_kept", 32'(mem[12'h321]), 32'h00ACE);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
